// File: rtl/bin_arb_pkg.sv
// Shared types and helpers for the bin arbiter controller.
package bin_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Binarizer mode select encoding.
  localparam logic SEL_TRU   = 1'b0;
  localparam logic SEL_UNARY = 1'b1;

  // Requester index width; never collapses below one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bin_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr.
module rr_arbiter import bin_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  int k;

  // Rotating priority search, wrapping at NUM_REQ (ptr is always < NUM_REQ).
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/bin_arbiter_ctrl.sv
// Shares one unary/TRU binarizer among NUM_REQ requesters, one job at a time.
// Optional macro BIN_ARB_TIMEOUT_EN adds a WAIT watchdog that returns an
// error response after TIMEOUT_CYCLES without bz_done_i.
module bin_arbiter_ctrl import bin_arb_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int VALUE_WIDTH    = 8,
  parameter int CMAX_WIDTH     = 3,
  parameter int BIN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0]  req_value_i,
  input  logic [NUM_REQ*CMAX_WIDTH-1:0]   req_cmax_i,
  input  logic [NUM_REQ-1:0]              req_sel_i,
  output logic                            bz_start_o,
  output logic [VALUE_WIDTH-1:0]          bz_value_o,
  output logic [CMAX_WIDTH-1:0]           bz_cmax_o,
  output logic                            bz_sel_o,
  input  logic [BIN_WIDTH-1:0]            bz_bin_i,
  input  logic [BIN_WIDTH-1:0]            bz_len_i,
  input  logic                            bz_done_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [id_width(NUM_REQ)-1:0]    rsp_id_o,
  output logic [BIN_WIDTH-1:0]            rsp_bin_o,
  output logic [BIN_WIDTH-1:0]            rsp_len_o,
  output logic                            rsp_err_o,
  output logic                            busy_o
);

  localparam int ID_W = id_width(NUM_REQ);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] START = ST_START;
  localparam logic [1:0] WAIT  = ST_WAIT;
  localparam logic [1:0] RESP  = ST_RESP;

  logic [1:0]             state;
  logic [ID_W-1:0]        ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        gnt_idx;
  logic                   gnt_any;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [CMAX_WIDTH-1:0]  cmax_q;
  logic                   sel_q;
  logic [ID_W-1:0]        id_q;
  logic [BIN_WIDTH-1:0]   bin_q;
  logic [BIN_WIDTH-1:0]   len_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .found (gnt_any)
  );

`ifdef BIN_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             timed_out;
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // FSM, grant pointer and latched job/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      value_q <= '0;
      cmax_q  <= '0;
      sel_q   <= SEL_TRU;
      id_q    <= '0;
      bin_q   <= '0;
      len_q   <= '0;
`ifdef BIN_ARB_TIMEOUT_EN
      wait_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          value_q <= req_value_i[int'(gnt_idx)*VALUE_WIDTH +: VALUE_WIDTH];
          cmax_q  <= req_cmax_i[int'(gnt_idx)*CMAX_WIDTH +: CMAX_WIDTH];
          sel_q   <= req_sel_i[gnt_idx];
          id_q    <= gnt_idx;
          ptr     <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
          state   <= START;
        end
        START: begin
          state <= WAIT;
`ifdef BIN_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
`ifdef BIN_ARB_TIMEOUT_EN
          wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          if (bz_done_i) begin
            bin_q <= bz_bin_i;
            len_q <= bz_len_i;
            state <= RESP;
`ifdef BIN_ARB_TIMEOUT_EN
            err_q <= 1'b0;
          end else if (timed_out) begin
            bin_q <= '0;
            len_q <= '0;
            err_q <= 1'b1;
            state <= RESP;
`endif
          end
        end
        RESP: if (rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Grant is only visible while idle and out of reset.
  assign req_ready_o = (state == IDLE && rst_n) ? grant : '0;
  assign bz_start_o  = (state == START);
  assign bz_value_o  = value_q;
  assign bz_cmax_o   = cmax_q;
  assign bz_sel_o    = sel_q;
  assign rsp_valid_o = (state == RESP);
  assign rsp_id_o    = id_q;
  assign rsp_bin_o   = bin_q;
  assign rsp_len_o   = len_q;
  assign busy_o      = (state != IDLE);
`ifdef BIN_ARB_TIMEOUT_EN
  assign rsp_err_o   = err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bin_arbiter_ctrl.sv
// Directed bench for bin_arbiter_ctrl; the bench plays the binarizer.
module tb_bin_arbiter_ctrl;
  localparam int N = 4, VW = 8, CW = 3, BW = 16;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]      req_valid_i, req_ready_o, req_sel_i;
  logic [N*VW-1:0]   req_value_i;
  logic [N*CW-1:0]   req_cmax_i;
  logic              bz_start_o, bz_sel_o, bz_done_i;
  logic [VW-1:0]     bz_value_o;
  logic [CW-1:0]     bz_cmax_o;
  logic [BW-1:0]     bz_bin_i, bz_len_i, rsp_bin_o, rsp_len_o;
  logic              rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
  logic [1:0]        rsp_id_o;

  int n_vec = 0, n_bad = 0;

  bin_arbiter_ctrl #(.NUM_REQ(N), .VALUE_WIDTH(VW), .CMAX_WIDTH(CW),
                     .BIN_WIDTH(BW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_value_i(req_value_i), .req_cmax_i(req_cmax_i), .req_sel_i(req_sel_i),
    .bz_start_o(bz_start_o), .bz_value_o(bz_value_o), .bz_cmax_o(bz_cmax_o),
    .bz_sel_o(bz_sel_o), .bz_bin_i(bz_bin_i), .bz_len_i(bz_len_i),
    .bz_done_i(bz_done_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_bin_o(rsp_bin_o), .rsp_len_o(rsp_len_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input int val, input int cmax, input bit sel);
    req_value_i[k*VW +: VW] = VW'(val);
    req_cmax_i[k*CW +: CW]  = CW'(cmax);
    req_sel_i[k]            = sel;
    req_valid_i[k]          = 1'b1;
  endtask

  // Full job starting at a negedge in IDLE; bench acts as the binarizer.
  task automatic job(input int id, input int val, input logic [15:0] bin,
                     input logic [15:0] len, input int dly, input bit keep);
    int n = 0;
    #1;
    while (req_ready_o == '0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("grant", 32'(req_ready_o), 32'(1) << id);
    @(negedge clk);
    if (!keep) req_valid_i = '0;
    chk("start", 32'(bz_start_o), 1);
    chk("start_value", 32'(bz_value_o), 32'(val));
    @(negedge clk);
    chk("start_pulse_end", 32'(bz_start_o), 0);
    repeat (dly) @(negedge clk);
    chk("wait_value_stable", 32'(bz_value_o), 32'(val));
    bz_bin_i = bin; bz_len_i = len; bz_done_i = 1'b1;
    @(negedge clk);
    bz_done_i = 1'b0; bz_bin_i = 16'h5A5A; bz_len_i = 16'h5A5A;
    chk("rsp_valid", 32'(rsp_valid_o), 1);
    chk("rsp_id", 32'(rsp_id_o), 32'(id));
    chk("rsp_bin", 32'(rsp_bin_o), 32'(bin));
    chk("rsp_len", 32'(rsp_len_o), 32'(len));
    chk("rsp_err", 32'(rsp_err_o), 0);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("rsp_drop", 32'(rsp_valid_o), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    req_valid_i = '0; req_sel_i = '0; req_value_i = '0; req_cmax_i = '0;
    bz_bin_i = '0; bz_len_i = '0; bz_done_i = 1'b0; rsp_ready_i = 1'b0;

    // Reset state, including a request held during reset.
    req_valid_i = 4'hF;
    #2;
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_start", 32'(bz_start_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rst_value", 32'(bz_value_o), 0);
    req_valid_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single unary request on slot 2: value 3 -> 1110, len 4.
    set_req(2, 3, 7, 1'b1);
    job(2, 3, 16'h000E, 16'd4, 2, 1'b0);

    // TRU value 7 cMax 3 on slot 1 with a stale done held through IDLE/START.
    bz_done_i = 1'b1; bz_bin_i = 16'hFFFF; bz_len_i = 16'hFFFF;
    set_req(1, 7, 3, 1'b0);
    #1 chk("tru_grant", 32'(req_ready_o), 32'h2);
    @(negedge clk);
    req_valid_i = '0;
    chk("tru_start", 32'(bz_start_o), 1);
    chk("tru_cmax", 32'(bz_cmax_o), 3);
    chk("tru_sel", 32'(bz_sel_o), 0);
    @(negedge clk);
    chk("stale_done_ignored", 32'(rsp_valid_o), 0);
    chk("tru_busy", 32'(busy_o), 1);
    bz_done_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("tru_value_stable", 32'(bz_value_o), 7);
    end
    bz_bin_i = 16'h0007; bz_len_i = 16'd3; bz_done_i = 1'b1;
    @(negedge clk);
    bz_done_i = 1'b0; bz_bin_i = 16'hAAAA; bz_len_i = 16'hAAAA;
    set_req(0, 2, 7, 1'b1);
    set_req(3, 5, 7, 1'b1);
    // Backpressure: response held, no new grant or start.
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_valid", 32'(rsp_valid_o), 1);
      chk("hold_id", 32'(rsp_id_o), 1);
      chk("hold_bin", 32'(rsp_bin_o), 32'h7);
      chk("hold_len", 32'(rsp_len_o), 3);
      chk("hold_ready", 32'(req_ready_o), 0);
      chk("hold_start", 32'(bz_start_o), 0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    // Pointer is 2, so requesters {0,3} resolve to 3.
    job(3, 5, 16'h003E, 16'd6, 1, 1'b0);

    // Reset in WAIT discards the job and resets the pointer.
    set_req(2, 4, 7, 1'b1);
    #1 chk("rw_grant", 32'(req_ready_o), 32'h4);
    @(negedge clk);
    req_valid_i = '0;
    @(negedge clk);
    chk("rw_in_wait", 32'(busy_o), 1);
    rst_n = 1'b0; bz_done_i = 1'b1; bz_bin_i = 16'h1234;
    #1;
    chk("rw_busy", 32'(busy_o), 0);
    chk("rw_value", 32'(bz_value_o), 0);
    chk("rw_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rw_rsp_id", 32'(rsp_id_o), 0);
    @(negedge clk);
    rst_n = 1'b1; bz_done_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rw_no_rsp", 32'(rsp_valid_o), 0);
    end
    req_valid_i = 4'b1001;
    job(0, 2, 16'h0006, 16'd3, 2, 1'b0);

    // All four requesting continuously from reset: 0,1,2,3,0.
    pulse_reset();
    for (int k = 0; k < N; k++) set_req(k, k + 1, 7, 1'b1);
    job(0, 1, 16'h0002, 16'd2, 0, 1'b1);
    job(1, 2, 16'h0006, 16'd3, 1, 1'b1);
    job(2, 3, 16'h000E, 16'd4, 2, 1'b1);
    job(3, 4, 16'h001E, 16'd5, 3, 1'b1);
    job(0, 1, 16'h0002, 16'd2, 0, 1'b0);

`ifdef BIN_ARB_TIMEOUT_EN
    // Watchdog: no done for 64 WAIT cycles -> error response.
    set_req(1, 6, 7, 1'b1);
    #1 chk("to_grant", 32'(req_ready_o), 32'h2);
    @(negedge clk);
    req_valid_i = '0;
    @(negedge clk);
    repeat (63) @(negedge clk);
    chk("to_not_yet", 32'(rsp_valid_o), 0);
    @(negedge clk);
    chk("to_valid", 32'(rsp_valid_o), 1);
    chk("to_err", 32'(rsp_err_o), 1);
    chk("to_len", 32'(rsp_len_o), 0);
    chk("to_bin", 32'(rsp_bin_o), 0);
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("to_idle", 32'(busy_o), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_arbiter_ctrl.md
BIN_ARBITER_CTRL -- requirements
Module: bin_arbiter_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one unary/TRU binarizer; legal range 2..8.
REQ-002 Parameter VALUE_WIDTH, default 8: syntax-element value width.
REQ-003 Parameter CMAX_WIDTH, default 3: cMax width.
REQ-004 Parameter BIN_WIDTH, default 16: bin-string and bin-length width.
REQ-005 Parameter TIMEOUT_CYCLES, default 64: watchdog limit in WAIT (used only with BIN_ARB_TIMEOUT_EN).
REQ-006 Ports, clock and reset first: clk in 1, sole clock; rst_n in 1, asynchronous active-low reset.
REQ-007 req_valid_i in NUM_REQ, per-requester request; req_ready_o out NUM_REQ, one-hot accept.
REQ-008 req_value_i in NUM_REQ*VALUE_WIDTH; req_cmax_i in NUM_REQ*CMAX_WIDTH; req_sel_i in NUM_REQ (0=TRU, 1=unary); slot k at bits [k*W +: W].
REQ-009 bz_start_o out 1; bz_value_o out VALUE_WIDTH; bz_cmax_o out CMAX_WIDTH; bz_sel_o out 1: drive the binarizer.
REQ-010 bz_bin_i in BIN_WIDTH; bz_len_i in BIN_WIDTH; bz_done_i in 1: binarizer result.
REQ-011 rsp_valid_o out 1; rsp_ready_i in 1; rsp_id_o out $clog2(NUM_REQ); rsp_bin_o out BIN_WIDTH; rsp_len_o out BIN_WIDTH; rsp_err_o out 1; busy_o out 1 (state != IDLE).

Function
REQ-012 FSM states IDLE, START, WAIT, RESP; exactly one job in flight.
REQ-013 IDLE: if any req_valid_i, grant one requester round-robin, assert its req_ready_o bit in the same cycle, latch value/cmax/sel/id into registers, go to START; else stay.
REQ-014 Round-robin: search starts at pointer; after granting g, pointer = (g+1) mod NUM_REQ; pointer unchanged when nothing is granted.
REQ-015 req_ready_o is all-zero in every state except IDLE; requests arriving in other states wait.
REQ-016 START: bz_start_o=1 for exactly one cycle, then WAIT.
REQ-017 bz_value_o/bz_cmax_o/bz_sel_o are driven from latched registers and stay stable from START until the next IDLE grant.
REQ-018 bz_done_i is ignored in IDLE and START; sampled only in WAIT (stale done from a prior job is never seen).
REQ-019 WAIT: on bz_done_i=1 capture bz_bin_i and bz_len_i into rsp registers, go to RESP.
REQ-020 RESP: rsp_valid_o=1 and rsp_* held stable until rsp_ready_i=1; on handshake go to IDLE (no grant in that cycle).
REQ-021 Latency accept->START = 1 cycle; done->rsp_valid_o = 1 cycle; min back-to-back spacing = 4 cycles + binarizer run time.
REQ-022 Requester dropping req_valid_i in IDLE before grant is legal; requests are not queued internally.

Reset
REQ-023 On rst_n=0, at any time including mid-job: state=IDLE, pointer=0, all outputs 0, latched registers 0; in-flight job discarded, no response issued.
REQ-024 First cycle after reset release behaves as IDLE with requester 0 highest priority.

Configuration
REQ-025 Macro BIN_ARB_TIMEOUT_EN: when defined, a WAIT cycle counter counts up; reaching TIMEOUT_CYCLES without bz_done_i goes to RESP with rsp_err_o=1, rsp_bin_o=0, rsp_len_o=0; counter clears on entering WAIT.
REQ-026 Without BIN_ARB_TIMEOUT_EN: no counter logic, WAIT is indefinite, rsp_err_o tied 0.

Structure
REQ-027 Shared package bin_arb_pkg: FSM state enum, TRU/unary sel constants, ID-width localparam helper.
REQ-028 One sub-module rr_arbiter (NUM_REQ request vector + pointer in, one-hot grant and index out, purely combinational); FSM and datapath registers in bin_arbiter_ctrl.

Verification
REQ-029 Single request req 2 value=3 sel=1 -> ready_o=4'b0100 one cycle, start pulse next cycle, rsp_id=2, rsp_bin=16'h000E, rsp_len=4.
REQ-030 All 4 requesting continuously from reset -> grant order 0,1,2,3,0; no requester granted twice before all others.
REQ-031 TRU value=7 cMax=3 sel=0 -> rsp_bin=16'h0007, rsp_len=3; bz_value_o stable throughout WAIT.
REQ-032 rsp_ready_i held 0 for 10 cycles in RESP -> rsp outputs unchanged, req_ready_o stays 0, no new start.
REQ-033 rst_n asserted in WAIT -> all outputs 0 immediately, no rsp_valid_o after release, next grant to requester 0.
REQ-034 With BIN_ARB_TIMEOUT_EN, bz_done_i held 0 -> after 64 WAIT cycles rsp_valid_o=1, rsp_err_o=1, rsp_len_o=0.
